// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer converter, truncating toward zero.
// The stb/ack handshake is used on both sides, and the mantissa is aligned by an iterative one-bit shifter.
module float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    CONVERT,
    PUT_Z
  } state_t;

  state_t             state_q, state_d;
  logic        [31:0] a_q, a_d;
  logic        [31:0] m_q, m_d;
  logic signed [9:0]  e_q, e_d;
  logic               s_q, s_d;
  logic        [31:0] z_q, z_d;
  logic               ack_q, ack_d;
  logic               stb_q, stb_d;

  logic exp_zero;
  logic too_big;
  logic too_small;
  logic in_hs;

  // The exponent field is zero for zero and for denormals. Both of these truncate to 0.
  assign exp_zero  = (a_q[30:23] == 8'd0);
  assign too_big   = (e_q > 10'sd30);
  assign too_small = (e_q < 10'sd0);
  assign in_hs     = input_a_stb && ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      m_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      e_q     <= e_d;
      s_q     <= s_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:   if (in_hs) state_d = UNPACK;
      UNPACK:  state_d = SPECIAL;
      SPECIAL: state_d = (exp_zero || too_big || too_small) ? PUT_Z : CONVERT;
      CONVERT: if (e_q >= 10'sd31) state_d = PUT_Z;
      PUT_Z:   if (output_z_ack) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  // Datapath and registered handshake outputs. The ack is raised again in the same cycle
  // as the output handshake, so it is already visible in the first GET_A cycle.
  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    e_d   = e_q;
    s_d   = s_q;
    z_d   = z_q;
    ack_d = ack_q;
    stb_d = stb_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (in_hs) begin
          a_d   = input_a;
          ack_d = 1'b0;
        end
      end
      UNPACK: begin
        m_d = {1'b1, a_q[22:0], 8'd0};
        e_d = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        s_d = a_q[31];
      end
      SPECIAL: begin
        if (exp_zero) begin
          z_d   = 32'd0;
          stb_d = 1'b1;
        end else if (too_big) begin
          z_d   = 32'h8000_0000;
          stb_d = 1'b1;
        end else if (too_small) begin
          z_d   = 32'd0;
          stb_d = 1'b1;
        end
      end
      CONVERT: begin
        if (e_q < 10'sd31) begin
          m_d = m_q >> 1;
          e_d = e_q + 10'sd1;
        end else begin
          z_d   = s_q ? (~m_q + 32'd1) : m_q;
          stb_d = 1'b1;
        end
      end
      PUT_Z: begin
        if (output_z_ack) begin
          stb_d = 1'b0;
          ack_d = 1'b1;
        end
      end
      default: begin
        ack_d = 1'b0;
        stb_d = 1'b0;
      end
    endcase
  end

  assign input_a_ack  = ack_q;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;

endmodule

// File: tb/tb_float_to_int.sv
// Testbench for float_to_int. It applies directed and randomized operands and checks
// each result and its latency against an arithmetic model of float truncation.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checkCount = 0;
  int errorCount = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value model: the integer equals mant * 2^(exp-150), truncated toward zero.
  function automatic logic [31:0] refConvert(input logic [31:0] f);
    int          expField;
    longint      mag;
    logic [23:0] mant;
    expField = int'(f[30:23]);
    if (expField == 0) return 32'd0;
    if (expField >= 158) return 32'h8000_0000;
    if (expField < 127) return 32'd0;
    mant = {1'b1, f[22:0]};
    if (expField >= 150) mag = longint'(mant) << (expField - 150);
    else                 mag = longint'(mant) >> (150 - expField);
    return f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  // Latency model: the number of cycles from the input handshake to the strobe.
  function automatic int refLatency(input logic [31:0] f);
    int expField;
    expField = int'(f[30:23]);
    if (expField == 0 || expField >= 158 || expField < 127) return 3;
    return 4 + (31 - (expField - 127));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic sendInput(input logic [31:0] val);
    int waitCycles;
    waitCycles = 0;
    while (!input_a_ack && waitCycles < 10) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("ackReady", {31'd0, input_a_ack}, 32'd1);
    input_a     = val;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
  endtask

  task automatic applyStimulus(input logic [31:0] val, input int ackDelay);
    int          n;
    logic [31:0] expZ;
    expZ = refConvert(val);
    output_z_ack = 1'($urandom_range(0, 1));
    sendInput(val);
    n = 1;
    while (!output_z_stb && n < 60) begin
      input_a_stb = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    input_a_stb = 1'b0;
    checkOutput("latency", 32'(n), 32'(refLatency(val)));
    checkOutput("result", output_z, expZ);
    for (int i = 0; i < ackDelay; i++) begin
      output_z_ack = 1'b0;
      @(posedge clk); #1;
      checkOutput("holdZ", output_z, expZ);
      checkOutput("holdStb", {31'd0, output_z_stb}, 32'd1);
      checkOutput("holdAck", {31'd0, input_a_ack}, 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'($urandom_range(0, 1));
    checkOutput("reArm", {31'd0, input_a_ack}, 32'd1);
    checkOutput("stbDrop", {31'd0, output_z_stb}, 32'd0);
  endtask

  logic [31:0] directedVals [15] = '{
    32'h3F80_0000, 32'h4E80_0000, 32'hC020_0000,
    32'h3F40_0000, 32'h8000_0000, 32'h0000_0001, 32'h4F32_D05E,
    32'h7FC0_0000, 32'hFF80_0000, 32'hCF00_0000, 32'h42F6_0000,
    32'h4040_0000, 32'hC120_0000, 32'h47C3_5000, 32'h4EFF_FFFF
  };
  int directedDelays [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 0, 2};

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] randVal;
    rst          = 1'b1;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    #12;
    checkOutput("rstAck", {31'd0, input_a_ack}, 32'd0);
    checkOutput("rstStb", {31'd0, output_z_stb}, 32'd0);
    checkOutput("rstZ", output_z, 32'd0);
    @(posedge clk); #4;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("firstAck", {31'd0, input_a_ack}, 32'd1);

    for (int i = 0; i < 15; i++) applyStimulus(directedVals[i], directedDelays[i]);

    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 3) == 0) randVal = $urandom;
      else randVal = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 162)), 23'($urandom)};
      applyStimulus(randVal, $urandom_range(0, 3));
    end

    // An asynchronous reset during CONVERT must drop the ack immediately.
    sendInput(32'h3F80_0000);
    repeat (8) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    checkOutput("midRstAck", {31'd0, input_a_ack}, 32'd0);
    checkOutput("midRstStb", {31'd0, output_z_stb}, 32'd0);
    @(posedge clk); #4;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postRstAck", {31'd0, input_a_ack}, 32'd1);
    applyStimulus(32'h4000_0000, 0);

    // An asynchronous reset while a result is held under backpressure discards that result.
    output_z_ack = 1'b0;
    sendInput(32'h42F6_0000);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("heldStb", {31'd0, output_z_stb}, 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("putRstStb", {31'd0, output_z_stb}, 32'd0);
    checkOutput("putRstZ", output_z, 32'd0);
    @(posedge clk); #4;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(32'hC020_0000, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
